// File: rtl/mem_port_arbiter.sv
// Burst arbiter sharing one single-port feature/weight RAM between NUM_REQ requesters.
// Build option: define ARB_FIXED_PRIO_EN for fixed lowest-index-first priority (default round-robin).
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_SZ = 16,
  parameter int unsigned DATA_SZ = 16,
  parameter int unsigned LEN_SZ  = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_SZ-1:0] req_addr,
  input  logic [NUM_REQ*LEN_SZ-1:0]  req_len,
  input  logic [NUM_REQ*DATA_SZ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         beat_ack,
  output logic [NUM_REQ-1:0]         rvalid,
  output logic [DATA_SZ-1:0]         rdata,
  output logic [NUM_REQ-1:0]         done,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [ADDR_SZ-1:0]         ram_addr,
  output logic [DATA_SZ-1:0]         ram_wdata,
  input  logic [DATA_SZ-1:0]         ram_rdata
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [LEN_SZ-1:0]    beat_q, beat_d;
  logic [LEN_SZ-1:0]    len_q, len_d;
  logic [ADDR_SZ-1:0]   base_q, base_d;
  logic                 we_q, we_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   beat_ack_q, beat_ack_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 ram_en_q, ram_en_d;
  logic                 ram_we_q, ram_we_d;
  logic [ADDR_SZ-1:0]   ram_addr_q, ram_addr_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;

  logic [ADDR_SZ-1:0]   addr_a  [NUM_REQ];
  logic [LEN_SZ-1:0]    len_a   [NUM_REQ];
  logic [DATA_SZ-1:0]   wdata_a [NUM_REQ];

  // Unpack the flat per-requester buses
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_a[g]  = req_addr[g*ADDR_SZ +: ADDR_SZ];
    assign len_a[g]   = req_len[g*LEN_SZ +: LEN_SZ];
    assign wdata_a[g] = req_wdata[g*DATA_SZ +: DATA_SZ];
  end

  // Winner selection among pending requests
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!win_found && req[IDX_W'(i)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
`else
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!win_found && req[IDX_W'((32'(rr_q) + 32'(i)) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((32'(rr_q) + 32'(i)) % NUM_REQ);
      end
    end
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    beat_d     = beat_q;
    len_d      = len_q;
    base_d     = base_q;
    we_d       = we_q;
    gnt_d      = '0;
    beat_ack_d = '0;
    done_d     = '0;
    ram_en_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = '0;
    // Read data returns one cycle after each read beat
    rvalid_d   = (ram_en_q && !ram_we_q) ? gnt_q : '0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BURST;
          owner_d = win_idx;
          beat_d  = '0;
          len_d   = len_a[win_idx];
          base_d  = addr_a[win_idx];
          we_d    = req_we[win_idx];
          gnt_d[win_idx] = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
          rr_d = IDX_W'((32'(win_idx) + 32'd1) % NUM_REQ);
`endif
          if (len_a[win_idx] != '0) begin
            ram_en_d   = 1'b1;
            ram_we_d   = req_we[win_idx];
            ram_addr_d = addr_a[win_idx];
            beat_ack_d[win_idx] = req_we[win_idx];
          end
        end
      end
      BURST: begin
        gnt_d = gnt_q;
        // A zero-length burst spends one granted cycle here with no RAM access
        if (len_q == '0 || beat_q == len_q - LEN_SZ'(1)) begin
          state_d = DRAIN;
          done_d  = gnt_q;
        end else begin
          beat_d     = beat_q + LEN_SZ'(1);
          ram_en_d   = 1'b1;
          ram_we_d   = we_q;
          ram_addr_d = base_q + ADDR_SZ'(beat_q + LEN_SZ'(1));
          beat_ack_d = we_q ? gnt_q : '0;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      beat_q     <= '0;
      len_q      <= '0;
      base_q     <= '0;
      we_q       <= 1'b0;
      gnt_q      <= '0;
      beat_ack_q <= '0;
      rvalid_q   <= '0;
      done_q     <= '0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      base_q     <= base_d;
      we_q       <= we_d;
      gnt_q      <= gnt_d;
      beat_ack_q <= beat_ack_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  assign gnt      = gnt_q;
  assign beat_ack = beat_ack_q;
  assign rvalid   = rvalid_q;
  assign done     = done_q;
  assign ram_en   = ram_en_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;

  // Write word and read data pass straight through so beat_ack can step the word each cycle
  assign ram_wdata = ram_en_q ? wdata_a[owner_q] : '0;
  assign rdata     = (|rvalid_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed bursts, a RAM model and a negedge monitor.
module tb_mem_port_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req, req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*LW-1:0]  req_len;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     gnt, beat_ack, rvalid, done;
  logic [DW-1:0]     rdata;
  logic              ram_en, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata, ram_rdata;

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_SZ(AW), .DATA_SZ(DW), .LEN_SZ(LW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .beat_ack(beat_ack),
    .rvalid(rvalid), .rdata(rdata), .done(done), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Intended RAM contents for read expectations
  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (a >= 16'h0100 && a <= 16'h0103) return a - 16'h00FF;
    return pat(a);
  endfunction

  // Synchronous single-port RAM, read data one cycle after ram_en
  logic [DW-1:0] mem [0:65535];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 65536; a++) mem[a] <= pat(16'(a));
      mem[16'h0100] <= 16'd1;
      mem[16'h0101] <= 16'd2;
      mem[16'h0102] <= 16'd3;
      mem[16'h0103] <= 16'd4;
      mem_init <= 1'b1;
    end else if (ram_en === 1'b1 && ram_we === 1'b1) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (ram_en === 1'b1) ram_rdata <= mem[ram_addr];
  end

  typedef struct packed { int cyc; logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; } ram_ev_t;
  typedef struct packed { int cyc; int idx; logic [DW-1:0] data; } rd_ev_t;
  typedef struct packed { int cyc; int idx; } dn_ev_t;
  typedef struct packed { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } mem_ev_t;

  ram_ev_t q_ram[$];
  rd_ev_t  q_rd[$];
  dn_ev_t  q_dn[$];
  mem_ev_t q_mem[$];
  int      q_zero[$];

  int   total = 0;
  int   bad = 0;
  int   n_timeout = 0;
  logic fin_req = 1'b0;
  logic fin_done = 1'b0;

  logic [DW-1:0] wq [NR][8];
  int            wptr [NR];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  ram_ev_t me;
  rd_ev_t  mr;
  dn_ev_t  md;
  mem_ev_t mm;

  // Monitor: pop and compare whenever the DUT presents an event
  always @(negedge clk) begin
    if (ram_en === 1'b1) begin
      check("ram_expected", 64'(q_ram.size() != 0), 64'd1);
      if (q_ram.size() != 0) begin
        me = q_ram.pop_front();
        check("ram_cycle", 64'(cyc), 64'(me.cyc));
        check("ram_addr", 64'(ram_addr), 64'(me.addr));
        check("ram_we", 64'(ram_we), 64'(me.we));
        if (me.we) check("ram_wdata", 64'(ram_wdata), 64'(me.wdata));
      end
    end
    for (int i = 0; i < int'(NR); i++) begin
      if (rvalid[i] === 1'b1) begin
        check("rvalid_expected", 64'(q_rd.size() != 0), 64'd1);
        if (q_rd.size() != 0) begin
          mr = q_rd.pop_front();
          check("rvalid_cycle", 64'(cyc), 64'(mr.cyc));
          check("rvalid_idx", 64'(i), 64'(mr.idx));
          check("rdata", 64'(rdata), 64'(mr.data));
        end
      end
      if (done[i] === 1'b1) begin
        check("done_expected", 64'(q_dn.size() != 0), 64'd1);
        if (q_dn.size() != 0) begin
          md = q_dn.pop_front();
          check("done_cycle", 64'(cyc), 64'(md.cyc));
          check("done_idx", 64'(i), 64'(md.idx));
          check("gnt_at_done", 64'(gnt), 64'(1 << i));
        end
      end
    end
    if (gnt !== '0) check("gnt_onehot", 64'($countones(gnt)), 64'd1);
    if (q_zero.size() != 0 && q_zero[0] == cyc) begin
      void'(q_zero.pop_front());
      check("outputs_zero", 64'({gnt, beat_ack, rvalid, done, ram_en, ram_we,
                                 |ram_addr, |ram_wdata, |rdata}), 64'd0);
    end
    while (q_mem.size() != 0 && q_mem[0].cyc == cyc) begin
      mm = q_mem.pop_front();
      check("ram_content", 64'(mem[mm.addr]), 64'(mm.data));
    end
    if (fin_req && !fin_done) begin
      check("queues_drained", 64'(q_ram.size() + q_rd.size() + q_dn.size() + q_mem.size() + q_zero.size()), 64'd0);
      check("stim_timeouts", 64'(n_timeout), 64'd0);
      fin_done = 1'b1;
    end
  end

  // One clock: requesters drop req after done and step write data after beat_ack
  task automatic tick();
    logic [NR-1:0] d, a;
    @(negedge clk);
    d = done;
    a = beat_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(NR); i++) begin
      if (d[i] === 1'b1) req[i] = 1'b0;
      if (a[i] === 1'b1) begin
        wptr[i]++;
        req_wdata[i*DW +: DW] = wq[i][wptr[i] % 8];
      end
    end
  endtask

  task automatic issue(input int idx, input logic we, input logic [AW-1:0] addr, input int len);
    req_we[idx]           = we;
    req_addr[idx*AW +: AW] = addr;
    req_len[idx*LW +: LW]  = LW'(len);
    wptr[idx]             = 0;
    req_wdata[idx*DW +: DW] = wq[idx][0];
    req[idx]              = 1'b1;
  endtask

  // Expected events for a burst whose request is sampled in cycle t
  task automatic expect_burst(input int idx, input logic we, input logic [AW-1:0] addr,
                              input int len, input int t, input int cut, input bit aborted);
    int nrd;
    for (int k = 0; k < cut; k++)
      q_ram.push_back(ram_ev_t'{t + 1 + k, addr + AW'(k), we, wq[idx][k % 8]});
    nrd = aborted ? cut - 1 : len;
    if (!we)
      for (int k = 0; k < nrd; k++)
        q_rd.push_back(rd_ev_t'{t + 2 + k, idx, model_rd(addr + AW'(k))});
    if (!aborted) q_dn.push_back(dn_ev_t'{(len == 0) ? t + 2 : t + len + 1, idx});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_ram.size() + q_rd.size() + q_dn.size() + q_zero.size() + q_mem.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      n_timeout++;
      q_ram.delete(); q_rd.delete(); q_dn.delete(); q_zero.delete(); q_mem.delete();
    end
    tick();
    tick();
  endtask

  initial begin
    int t;
    reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    for (int i = 0; i < int'(NR); i++) begin
      wptr[i] = 0;
      for (int k = 0; k < 8; k++) wq[i][k] = '0;
    end
    wq[2][0] = 16'h0007; wq[2][1] = 16'hFFF8; wq[2][2] = 16'h0009;
    repeat (3) @(posedge clk);
    #1;
    q_zero.push_back(cyc);
    tick();
    reset = 1'b0;
    tick();

    // Single read burst
    issue(1, 1'b0, 16'h0100, 4);
    expect_burst(1, 1'b0, 16'h0100, 4, cyc, 4, 1'b0);
    wait_idle();

    // Single write burst, data stepped on beat_ack
    issue(2, 1'b1, 16'h0400, 3);
    expect_burst(2, 1'b1, 16'h0400, 3, cyc, 3, 1'b0);
    wait_idle();
    q_mem.push_back(mem_ev_t'{cyc + 1, 16'h0400, 16'h0007});
    q_mem.push_back(mem_ev_t'{cyc + 1, 16'h0401, 16'hFFF8});
    q_mem.push_back(mem_ev_t'{cyc + 1, 16'h0402, 16'h0009});
    wait_idle();

    // Zero-length burst
    issue(3, 1'b0, 16'h0050, 0);
    expect_burst(3, 1'b0, 16'h0050, 0, cyc, 0, 1'b0);
    wait_idle();

    // Address wrap
    issue(0, 1'b0, 16'hFFFE, 4);
    expect_burst(0, 1'b0, 16'hFFFE, 4, cyc, 4, 1'b0);
    wait_idle();

    // Requester drops req and scrambles parameters mid-burst
    issue(0, 1'b0, 16'h0300, 6);
    expect_burst(0, 1'b0, 16'h0300, 6, cyc, 6, 1'b0);
    repeat (3) tick();
    req[0] = 1'b0;
    req_addr[0 +: AW] = 16'hDEAD;
    req_len[0 +: LW]  = LW'(1);
    wait_idle();

    // Reset during beat 5 of a 10-beat read
    issue(1, 1'b0, 16'h0200, 10);
    t = cyc;
    expect_burst(1, 1'b0, 16'h0200, 10, t, 6, 1'b1);
    repeat (6) tick();
    reset = 1'b1;
    req[1] = 1'b0;
    q_zero.push_back(t + 7);
    tick();
    reset = 1'b0;
    wait_idle();
    issue(2, 1'b0, 16'h0100, 2);
    expect_burst(2, 1'b0, 16'h0100, 2, cyc, 2, 1'b0);
    wait_idle();

    // Four-way contention from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < int'(NR); i++) issue(i, 1'b0, 16'h1000 + AW'(i * 256), 2);
    t = cyc;
    for (int i = 0; i < int'(NR); i++)
      expect_burst(i, 1'b0, 16'h1000 + AW'(i * 256), 2, t + 4 * i, 2, 1'b0);
    wait_idle();

    fin_req = 1'b1;
    for (int n = 0; n < 10 && !fin_done; n++) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
